// File: rtl/clock_phase_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clock_phase_monitor_pkg
//
// Shared definitions for the clock phase monitor: the FSM state encoding,
// the default lock length, the fault-counter width and a saturating
// increment helper for that counter.
//
// Contents:
//   CPM_LOCK_LEN_DEFAULT  default number of consecutive toggles to lock
//   CPM_ERR_W             width of the saturating fault counter
//   CPM_ERR_MAX           saturation value of the fault counter
//   cpm_state_e           monitor FSM state encoding
//   cpm_sat_inc()         saturating increment for the fault counter
// -----------------------------------------------------------------------------
package clock_phase_monitor_pkg;

    localparam int unsigned CPM_LOCK_LEN_DEFAULT = 4;
    localparam int unsigned CPM_ERR_W            = 8;
    localparam logic [CPM_ERR_W-1:0] CPM_ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FAULT    = 2'd3
    } cpm_state_e;

    // Holds at CPM_ERR_MAX instead of wrapping back to zero.
    function automatic logic [CPM_ERR_W-1:0] cpm_sat_inc(input logic [CPM_ERR_W-1:0] v);
        return (v == CPM_ERR_MAX) ? v : v + CPM_ERR_W'(1);
    endfunction

endpackage

// File: rtl/clock_phase_monitor.sv
// -----------------------------------------------------------------------------
// clock_phase_monitor
//
// Watches the divide-by-2 phase bit produced by the clock divider and
// verifies that it alternates on every fast clock. After LOCK_LEN
// consecutive toggles the monitor declares lock and drives the fetch/exec
// datapath enables from the phase. A missed toggle while locked produces a
// one-cycle FAULT (err pulse, err_count increment) and the monitor goes
// back to acquiring lock.
//
// No valid/ready handshake: every output is a registered level that is
// meaningful on every clkin cycle.
//
// Ports:
//   clkin        in   fast clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   phase_in     in   divide-by-2 phase bit, synchronous to clkin
//   clr_counts   in   synchronous clear of err_count and cycle_count
//   fetch_en     out  datapath enable for phase 0 (only while locked)
//   exec_en      out  datapath enable for phase 1 (only while locked)
//   locked       out  phase alternation verified
//   err          out  one-cycle pulse while the FSM is in FAULT
//   err_count    out  saturating count of detected faults
//   cycle_count  out  completed slow cycles while locked (wraps)
//   dbg_state_o  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module clock_phase_monitor
    import clock_phase_monitor_pkg::*;
#(
    parameter int unsigned LOCK_LEN = CPM_LOCK_LEN_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic                 phase_in,
    input  logic                 clr_counts,
    output logic                 fetch_en,
    output logic                 exec_en,
    output logic                 locked,
    output logic                 err,
    output logic [CPM_ERR_W-1:0] err_count,
    output logic [CNT_W-1:0]     cycle_count,
    output cpm_state_e           dbg_state_o
);

    // run_len only needs to reach LOCK_LEN-1; the lock edge itself is
    // recognised by comparing against that value rather than counting past it.
    localparam int unsigned RUN_W = (LOCK_LEN > 2) ? $clog2(LOCK_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_LEN - 1);

    // ---------------------------------------------------------------------
    // State and phase history
    // ---------------------------------------------------------------------
    cpm_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             phase_q;
    logic             toggle;

    // Output and counter registers
    logic                 fetch_en_q, fetch_en_d;
    logic                 exec_en_q, exec_en_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [CPM_ERR_W-1:0] err_count_q;
    logic [CNT_W-1:0]     cycle_count_q;

    // Counter events derived from the FSM
    logic fault_entry;
    logic slow_cycle_done;

    assign toggle = phase_in ^ phase_q;

    // ---------------------------------------------------------------------
    // FSM process 1: state register (plus phase history and run length)
    // ---------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q   <= ST_UNLOCKED;
            phase_q   <= 1'b0;
            run_len_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_in;
            run_len_q <= run_len_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        case (state_q)
            // One settling cycle: phase_q is loaded with a real sample
            // before any toggle is counted.
            ST_UNLOCKED: begin
                state_d   = ST_ACQUIRE;
                run_len_d = '0;
            end
            ST_ACQUIRE: begin
                if (toggle) begin
                    if (run_len_q == RUN_LAST) begin
                        state_d   = ST_LOCKED;
                        run_len_d = '0;
                    end else begin
                        run_len_d = run_len_q + RUN_W'(1);
                    end
                end else begin
                    // Any stall restarts the acquisition run.
                    run_len_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!toggle) begin
                    state_d = ST_FAULT;
                end
            end
            // Single-cycle fault marker; the phase seen here is ignored.
            ST_FAULT: begin
                state_d   = ST_ACQUIRE;
                run_len_d = '0;
            end
            default: begin
                state_d   = ST_UNLOCKED;
                run_len_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM process 3: output logic (next values of the registered outputs)
    // ---------------------------------------------------------------------
    always_comb begin
        locked_d        = (state_d == ST_LOCKED);
        // Enables are decoded from the phase being sampled now, so they
        // appear one cycle after phase_in and are mutually exclusive.
        fetch_en_d      = locked_d & ~phase_in;
        exec_en_d       = locked_d &  phase_in;
        err_d           = (state_d == ST_FAULT);
        fault_entry     = (state_d == ST_FAULT) && (state_q != ST_FAULT);
        // A toggle down to phase 0 closes a phase-1 half, i.e. one full
        // slow cycle has completed.
        slow_cycle_done = (state_q == ST_LOCKED) && toggle && !phase_in;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            fetch_en_q <= 1'b0;
            exec_en_q  <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fetch_en_q <= fetch_en_d;
            exec_en_q  <= exec_en_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Fault counter: saturating, clear wins over a coincident increment
    // ---------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (clr_counts) begin
            err_count_q <= '0;
        end else if (fault_entry) begin
            err_count_q <= cpm_sat_inc(err_count_q);
        end
    end

    // ---------------------------------------------------------------------
    // Slow-cycle counter: wraps modulo 2^CNT_W, clear wins
    // ---------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else if (clr_counts) begin
            cycle_count_q <= '0;
        end else if (slow_cycle_done) begin
            cycle_count_q <= cycle_count_q + CNT_W'(1);
        end
    end

    assign fetch_en    = fetch_en_q;
    assign exec_en     = exec_en_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign cycle_count = cycle_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_phase_monitor
//
// Drives directed and random phase patterns into clock_phase_monitor
// (LOCK_LEN = 4, CNT_W = 4). A reference model described in terms of toggle
// streaks, a lock flag and a one-cycle blank after reset or a miss predicts
// all outputs after each edge; predictions go into exp_q and a separate
// monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_phase_monitor;
    import clock_phase_monitor_pkg::*;

    localparam int LOCK_LEN = 4;
    localparam int CNT_W    = 4;
    localparam int W        = 2 + 4 + 8 + CNT_W;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic             clkin = 1'b0;
    logic             reset = 1'b1;
    logic             phase_in = 1'b0;
    logic             clr_counts = 1'b0;
    logic             fetch_en, exec_en, locked, err;
    logic [7:0]       err_count;
    logic [CNT_W-1:0] cycle_count;
    cpm_state_e       dbg_state;

    always #5 clkin = ~clkin;

    clock_phase_monitor #(
        .LOCK_LEN (LOCK_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .phase_in    (phase_in),
        .clr_counts  (clr_counts),
        .fetch_en    (fetch_en),
        .exec_en     (exec_en),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count),
        .cycle_count (cycle_count),
        .dbg_state_o (dbg_state)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    //   m_blank       : the cycle after reset or after a miss, phase ignored
    //   m_blank_fault : that blank cycle was caused by a miss (err visible)
    //   m_lock        : alternation verified
    //   m_streak      : consecutive toggles seen while acquiring
    // ---------------------------------------------------------------------
    logic m_blank = 1'b1, m_blank_fault = 1'b0, m_lock = 1'b0;
    logic m_prev = 1'b0, m_ph = 1'b0;
    int   m_streak = 0, m_ec = 0, m_cc = 0;

    task automatic model_step(input logic rst, input logic ph, input logic clr);
        logic tog;
        if (rst) begin
            m_blank = 1'b1; m_blank_fault = 1'b0; m_lock = 1'b0;
            m_prev = 1'b0; m_ph = 1'b0; m_streak = 0; m_ec = 0; m_cc = 0;
        end else begin
            tog = (ph != m_prev);
            if (m_blank) begin
                m_blank  = 1'b0;
                m_streak = 0;
            end else if (m_lock) begin
                if (!tog) begin
                    m_lock = 1'b0; m_blank = 1'b1; m_blank_fault = 1'b1;
                    m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                end else if (ph == 1'b0) begin
                    m_cc = (m_cc + 1) % (1 << CNT_W);
                end
            end else begin
                m_streak = tog ? m_streak + 1 : 0;
                if (m_streak == LOCK_LEN) begin
                    m_lock = 1'b1;
                    m_streak = 0;
                end
            end
            if (clr) begin
                m_ec = 0;
                m_cc = 0;
            end
            m_prev = ph;
            m_ph   = ph;
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [1:0] st;
        if (m_blank) st = m_blank_fault ? ST_FAULT : ST_UNLOCKED;
        else         st = m_lock ? ST_LOCKED : ST_ACQUIRE;
        return {st, m_lock, (m_blank & m_blank_fault), (m_lock & ~m_ph), (m_lock & m_ph),
                8'(m_ec), CNT_W'(m_cc)};
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: pops one prediction per cycle and compares every output
    // ---------------------------------------------------------------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clkin);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_state",       32'(dbg_state),   32'(e[CNT_W+13:CNT_W+12]));
                check("sb_locked",      32'(locked),      32'(e[CNT_W+11]));
                check("sb_err",         32'(err),         32'(e[CNT_W+10]));
                check("sb_fetch_en",    32'(fetch_en),    32'(e[CNT_W+9]));
                check("sb_exec_en",     32'(exec_en),     32'(e[CNT_W+8]));
                check("sb_err_count",   32'(err_count),   32'(e[CNT_W+7:CNT_W]));
                check("sb_cycle_count", 32'(cycle_count), 32'(e[CNT_W-1:0]));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    logic last_ph = 1'b0;

    task automatic step(input logic rst, input logic ph, input logic clr);
        reset      = rst;
        phase_in   = ph;
        clr_counts = clr;
        @(posedge clkin);
        #1;
        model_step(rst, ph, clr);
        exp_q.push_back(model_out());
        last_ph = ph;
    endtask

    task automatic tog();
        step(1'b0, ~last_ph, 1'b0);
    endtask

    task automatic hold();
        step(1'b0, last_ph, 1'b0);
    endtask

    // Watchdog: the run is a few thousand cycles; this bound is far above it.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic r_rst, r_clr, r_ph;

        // Reset state
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("rst_state",  32'(dbg_state), 32'(ST_UNLOCKED));
        check("rst_locked", 32'(locked), 0);
        check("rst_counts", 32'({err_count, cycle_count}), 0);

        // Clean alternation from 0: settle cycle, then 4 toggles to lock
        step(1'b0, 1'b0, 1'b0);
        check("acq_state", 32'(dbg_state), 32'(ST_ACQUIRE));
        repeat (3) tog();
        check("lock_early", 32'(locked), 0);
        tog();
        check("lock_on_4th", 32'(locked), 1);
        check("fetch_after_0", 32'({fetch_en, exec_en}), 32'(2'b10));
        tog();
        check("exec_after_1", 32'({fetch_en, exec_en}), 32'(2'b01));
        repeat (8) tog();

        // Held phase while locked: exactly one fault, then relock
        hold();
        check("hold_err",    32'(err), 1);
        check("hold_ec",     32'(err_count), 1);
        check("hold_locked", 32'({locked, fetch_en, exec_en}), 0);
        hold();
        hold();
        check("hold_err_once", 32'(err), 0);
        check("hold_ec_once",  32'(err_count), 1);
        repeat (3) tog();
        check("relock_early", 32'(locked), 0);
        tog();
        check("relock", 32'(locked), 1);

        // 17 slow cycles on a 4-bit counter wraps to 1
        repeat (4) tog();
        step(1'b0, ~last_ph, 1'b1);
        check("clr_cc", 32'(cycle_count), 0);
        repeat (34) tog();
        check("cc_wrap", 32'(cycle_count), 1);

        // 300 faults saturate the fault counter
        for (int i = 0; i < 300; i++) begin
            hold();
            repeat (6) tog();
        end
        check("ec_sat", 32'(err_count), 255);
        step(1'b0, last_ph, 1'b1);
        check("clr_vs_fault_ec",  32'(err_count), 0);
        check("clr_vs_fault_err", 32'(err), 1);
        repeat (6) tog();
        check("relock_after_clr", 32'(locked), 1);

        // Reset while locked with cycle_count = 7
        step(1'b0, ~last_ph, 1'b1);
        repeat (14) tog();
        check("cc_seven", 32'(cycle_count), 7);
        step(1'b1, ~last_ph, 1'b0);
        check("midlock_rst_outs",
              32'({fetch_en, exec_en, locked, err, err_count, cycle_count}), 0);
        check("midlock_rst_state", 32'(dbg_state), 32'(ST_UNLOCKED));
        hold();
        check("post_rst_acq", 32'(dbg_state), 32'(ST_ACQUIRE));

        // Stall inside acquisition restarts the run
        repeat (3) tog();
        hold();
        repeat (3) tog();
        check("stall_no_lock", 32'(locked), 0);
        tog();
        check("stall_lock", 32'(locked), 1);

        // Random phase patterns with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            r_clr = ($urandom_range(0, 99) < 4);
            r_ph  = ($urandom_range(0, 99) < 88) ? ~last_ph : last_ph;
            step(r_rst, r_ph, r_clr);
        end

        // Drain the scoreboard (bounded)
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clkin);
            #1;
        end
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
